// File: rtl/rect_overlay_ctrl.sv
// Rectangle overlay controller: shadow/active descriptor sets committed at vblank start,
// plus a 2-stage hit/priority pixel pipeline with matching hs/vs delay.

module rect_hit (
   input  logic        en_i,
   input  logic [10:0] xmin_i,
   input  logic [10:0] xmax_i,
   input  logic [10:0] ymin_i,
   input  logic [10:0] ymax_i,
   input  logic [10:0] hcount_i,
   input  logic [10:0] vcount_i,
   output logic        hit_o
);
   // An inverted range (min > max) simply never matches.
   assign hit_o = en_i && (hcount_i >= xmin_i) && (hcount_i <= xmax_i)
                       && (vcount_i >= ymin_i) && (vcount_i <= ymax_i);
endmodule

module rect_overlay_ctrl #(
   parameter int          NUM_RECT = 4,
   parameter logic [11:0] BG_COLOR = 12'h888,
   parameter int          IDX_W    = $clog2(NUM_RECT)
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic [10:0]      hcount,
   input  logic [10:0]      vcount,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             hblnk,
   input  logic             vblnk,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [IDX_W-1:0] cfg_idx,
   input  logic [10:0]      cfg_xmin,
   input  logic [10:0]      cfg_xmax,
   input  logic [10:0]      cfg_ymin,
   input  logic [10:0]      cfg_ymax,
   input  logic [11:0]      cfg_color,
   input  logic             cfg_en,
   output logic             pending,
   output logic             commit_pulse,
   output logic             hs,
   output logic             vs,
   output logic [3:0]       r,
   output logic [3:0]       g,
   output logic [3:0]       b
);
   typedef struct packed {
      logic        en;
      logic [10:0] xmin;
      logic [10:0] xmax;
      logic [10:0] ymin;
      logic [10:0] ymax;
      logic [11:0] color;
   } desc_t;

   typedef enum logic [1:0] {IDLE, PENDING, COMMIT} state_t;

   localparam logic [IDX_W:0] NUM_RECT_W = NUM_RECT[IDX_W:0];

   state_t               state_q, state_d;
   desc_t [NUM_RECT-1:0] shadow_q, active_q;
   desc_t                wr_desc;
   logic                 vblnk_q, vblnk_rise;
   logic                 wr_acc, wr_hit;
   logic                 ready_q, commit_q, pending_q;
   logic [NUM_RECT-1:0]  hit_c, hit_q;
   logic                 blank_q;
   logic [1:0]           hs_pipe_q, vs_pipe_q;
   logic [11:0]          rgb_d, rgb_q;

   assign vblnk_rise = vblnk && !vblnk_q;
   assign wr_acc     = cfg_valid && ready_q;
   assign wr_hit     = wr_acc && ({1'b0, cfg_idx} < NUM_RECT_W);

   always_comb begin
      wr_desc       = '0;
      wr_desc.en    = cfg_en;
      wr_desc.xmin  = cfg_xmin;
      wr_desc.xmax  = cfg_xmax;
      wr_desc.ymin  = cfg_ymin;
      wr_desc.ymax  = cfg_ymax;
      wr_desc.color = cfg_color;
   end

   // A write landing in the vblnk_rise cycle still makes this frame's commit.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (wr_hit) state_d = vblnk_rise ? COMMIT : PENDING;
         PENDING: if (vblnk_rise) state_d = COMMIT;
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         vblnk_q   <= 1'b0;
         ready_q   <= 1'b1;
         commit_q  <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         vblnk_q   <= vblnk;
         ready_q   <= (state_d != COMMIT);
         commit_q  <= (state_d == COMMIT);
         pending_q <= (state_d != IDLE);
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (wr_hit) shadow_q[cfg_idx] <= wr_desc;
         if (state_q == COMMIT) active_q <= shadow_q;
      end
   end

   for (genvar i = 0; i < NUM_RECT; i++) begin : g_rect
      rect_hit u_hit (
         .en_i     (active_q[i].en),
         .xmin_i   (active_q[i].xmin),
         .xmax_i   (active_q[i].xmax),
         .ymin_i   (active_q[i].ymin),
         .ymax_i   (active_q[i].ymax),
         .hcount_i (hcount),
         .vcount_i (vcount),
         .hit_o    (hit_c[i])
      );
   end

   // Walk from lowest priority up so index 0 is applied last and wins.
   always_comb begin
      rgb_d = BG_COLOR;
      for (int i = NUM_RECT - 1; i >= 0; i--)
         if (hit_q[i]) rgb_d = active_q[i].color;
      if (blank_q) rgb_d = '0;
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         hit_q     <= '0;
         blank_q   <= 1'b0;
         hs_pipe_q <= '0;
         vs_pipe_q <= '0;
         rgb_q     <= '0;
      end else begin
         hit_q     <= hit_c;
         blank_q   <= hblnk || vblnk;
         hs_pipe_q <= {hs_pipe_q[0], hsync};
         vs_pipe_q <= {vs_pipe_q[0], vsync};
         rgb_q     <= rgb_d;
      end
   end

   assign cfg_ready    = ready_q;
   assign commit_pulse = commit_q;
   assign pending      = pending_q;
   assign hs           = hs_pipe_q[1];
   assign vs           = vs_pipe_q[1];
   assign {r, g, b}    = rgb_q;
endmodule

// File: tb/tb_rect_overlay_ctrl.sv
// Directed bench for rect_overlay_ctrl: reset, commit timing, priority, and write edge cases.
module tb_rect_overlay_ctrl;
   localparam int NR = 5;
   localparam int IW = $clog2(NR);

   logic          pclk = 1'b0;
   logic          rst;
   logic [10:0]   hcount, vcount;
   logic          hsync, vsync, hblnk, vblnk;
   logic          cfg_valid, cfg_ready, cfg_en;
   logic [IW-1:0] cfg_idx;
   logic [10:0]   cfg_xmin, cfg_xmax, cfg_ymin, cfg_ymax;
   logic [11:0]   cfg_color;
   logic          pending, commit_pulse, hs, vs;
   logic [3:0]    r, g, b;
   logic [11:0]   rgb;
   int            n_pass = 0, n_total = 0;

   assign rgb = {r, g, b};

   always #5 pclk = ~pclk;

   rect_overlay_ctrl #(.NUM_RECT(NR)) dut (
      .pclk(pclk), .rst(rst), .hcount(hcount), .vcount(vcount),
      .hsync(hsync), .vsync(vsync), .hblnk(hblnk), .vblnk(vblnk),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_idx(cfg_idx),
      .cfg_xmin(cfg_xmin), .cfg_xmax(cfg_xmax), .cfg_ymin(cfg_ymin), .cfg_ymax(cfg_ymax),
      .cfg_color(cfg_color), .cfg_en(cfg_en), .pending(pending), .commit_pulse(commit_pulse),
      .hs(hs), .vs(vs), .r(r), .g(g), .b(b)
   );

   // All stimulus tasks start and end one time unit after a rising edge.
   task automatic set_cfg(input logic [IW-1:0] idx, input logic [10:0] x0, x1, y0, y1,
                          input logic [11:0] col, input logic en);
      cfg_idx = idx; cfg_xmin = x0; cfg_xmax = x1; cfg_ymin = y0; cfg_ymax = y1;
      cfg_color = col; cfg_en = en;
   endtask

   task automatic write(input logic [IW-1:0] idx, input logic [10:0] x0, x1, y0, y1,
                        input logic [11:0] col, input logic en);
      set_cfg(idx, x0, x1, y0, y1, col, en);
      cfg_valid = 1'b1;
      @(posedge pclk); #1;
      cfg_valid = 1'b0;
   endtask

   task automatic show_pix(input logic [10:0] h, v, input logic hb);
      hcount = h; vcount = v; hblnk = hb; vblnk = 1'b0;
      @(posedge pclk); @(posedge pclk); #1;
   endtask

   task automatic do_vblank(output logic cp1, rdy1, pend1, cp2, pend2);
      hblnk = 1'b0; vblnk = 1'b1;
      @(posedge pclk); #1;
      cp1 = commit_pulse; rdy1 = cfg_ready; pend1 = pending;
      @(posedge pclk); #1;
      cp2 = commit_pulse; pend2 = pending;
      repeat (2) @(posedge pclk);
      #1 vblnk = 1'b0;
      @(posedge pclk); #1;
   endtask

   task automatic test_reset();
      logic [15:0] hsp, vsp, bkp;
      hsp = 16'b1100_1010_0111_0010;
      vsp = 16'b0011_1001_0100_1110;
      bkp = 16'b0001_1000_0110_0011;
      rst = 1'b1; cfg_valid = 1'b0; set_cfg('0, '0, '0, '0, '0, '0, 1'b0);
      hcount = '0; vcount = '0; hsync = 1'b0; vsync = 1'b0; hblnk = 1'b0; vblnk = 1'b0;
      repeat (3) @(posedge pclk); #1;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", cfg_ready); else n_pass++;
      n_total++; if (pending !== 1'b0) $display("FAIL rst_pending got=%b exp=0", pending); else n_pass++;
      n_total++; if (commit_pulse !== 1'b0) $display("FAIL rst_commit got=%b exp=0", commit_pulse); else n_pass++;
      n_total++; if (rgb !== 12'h000) $display("FAIL rst_rgb got=%h exp=000", rgb); else n_pass++;
      n_total++; if ({hs, vs} !== 2'b00) $display("FAIL rst_hsvs got=%b exp=00", {hs, vs}); else n_pass++;
      rst = 1'b0;
      @(posedge pclk); #1;
      for (int j = 0; j < 18; j++) begin
         if (j >= 2) begin
            n_total++; if (hs !== hsp[j-2]) $display("FAIL hs_delay[%0d] got=%b exp=%b", j, hs, hsp[j-2]); else n_pass++;
            n_total++; if (vs !== vsp[j-2]) $display("FAIL vs_delay[%0d] got=%b exp=%b", j, vs, vsp[j-2]); else n_pass++;
            n_total++;
            if (rgb !== (bkp[j-2] ? 12'h000 : 12'h888)) $display("FAIL bg_pix[%0d] got=%h exp=%h", j, rgb, bkp[j-2] ? 12'h000 : 12'h888);
            else n_pass++;
         end
         if (j < 16) begin
            hsync = hsp[j]; vsync = vsp[j]; hblnk = bkp[j]; hcount = 11'(j * 7); vcount = 11'(j);
         end else begin
            hsync = 1'b0; vsync = 1'b0; hblnk = 1'b0;
         end
         @(posedge pclk); #1;
      end
   endtask

   task automatic test_single();
      logic cp1, rdy1, pend1, cp2, pend2;
      hcount = 11'd400; vcount = 11'd300; hblnk = 1'b0; vblnk = 1'b0;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL wr0_ready got=%b exp=1", cfg_ready); else n_pass++;
      write(3'd0, 11'd100, 11'd199, 11'd50, 11'd149, 12'hF00, 1'b1);
      n_total++; if (pending !== 1'b1) $display("FAIL wr0_pending got=%b exp=1", pending); else n_pass++;
      show_pix(11'd120, 11'd60, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL precommit_pix got=%h exp=888", rgb); else n_pass++;
      n_total++; if (pending !== 1'b1) $display("FAIL pending_hold got=%b exp=1", pending); else n_pass++;
      do_vblank(cp1, rdy1, pend1, cp2, pend2);
      n_total++; if (cp1 !== 1'b1) $display("FAIL commit_pulse got=%b exp=1", cp1); else n_pass++;
      n_total++; if (rdy1 !== 1'b0) $display("FAIL commit_ready got=%b exp=0", rdy1); else n_pass++;
      n_total++; if (pend1 !== 1'b1) $display("FAIL commit_pending got=%b exp=1", pend1); else n_pass++;
      n_total++; if (cp2 !== 1'b0) $display("FAIL pulse_width got=%b exp=0", cp2); else n_pass++;
      n_total++; if (pend2 !== 1'b0) $display("FAIL post_pending got=%b exp=0", pend2); else n_pass++;
      show_pix(11'd100, 11'd50, 1'b0);
      n_total++; if (rgb !== 12'hF00) $display("FAIL px_100_50 got=%h exp=F00", rgb); else n_pass++;
      show_pix(11'd199, 11'd149, 1'b0);
      n_total++; if (rgb !== 12'hF00) $display("FAIL px_199_149 got=%h exp=F00", rgb); else n_pass++;
      show_pix(11'd200, 11'd50, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL px_200_50 got=%h exp=888", rgb); else n_pass++;
      show_pix(11'd99, 11'd149, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL px_99_149 got=%h exp=888", rgb); else n_pass++;
      show_pix(11'd150, 11'd100, 1'b1);
      n_total++; if (rgb !== 12'h000) $display("FAIL px_hblank got=%h exp=000", rgb); else n_pass++;
   endtask

   task automatic test_overlap();
      logic cp1, rdy1, pend1, cp2, pend2;
      write(3'd1, 11'd150, 11'd249, 11'd100, 11'd199, 12'h0F0, 1'b1);
      do_vblank(cp1, rdy1, pend1, cp2, pend2);
      n_total++; if (cp1 !== 1'b1) $display("FAIL ovl_commit got=%b exp=1", cp1); else n_pass++;
      show_pix(11'd150, 11'd100, 1'b0);
      n_total++; if (rgb !== 12'hF00) $display("FAIL ovl_prio got=%h exp=F00", rgb); else n_pass++;
      show_pix(11'd220, 11'd180, 1'b0);
      n_total++; if (rgb !== 12'h0F0) $display("FAIL ovl_idx1 got=%h exp=0F0", rgb); else n_pass++;
   endtask

   task automatic test_vblnk_write();
      set_cfg(3'd3, 11'd300, 11'd309, 11'd20, 11'd29, 12'hABC, 1'b1);
      cfg_valid = 1'b1; hblnk = 1'b0; vblnk = 1'b1;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL rise_ready got=%b exp=1", cfg_ready); else n_pass++;
      @(posedge pclk); #1;
      cfg_valid = 1'b0;
      n_total++; if (commit_pulse !== 1'b1) $display("FAIL rise_commit got=%b exp=1", commit_pulse); else n_pass++;
      n_total++; if (cfg_ready !== 1'b0) $display("FAIL rise_ready_c got=%b exp=0", cfg_ready); else n_pass++;
      @(posedge pclk); #1;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL rise_ready_i got=%b exp=1", cfg_ready); else n_pass++;
      n_total++; if (pending !== 1'b0) $display("FAIL rise_pending got=%b exp=0", pending); else n_pass++;
      @(posedge pclk); #1 vblnk = 1'b0;
      show_pix(11'd300, 11'd20, 1'b0);
      n_total++; if (rgb !== 12'hABC) $display("FAIL rise_px_tl got=%h exp=ABC", rgb); else n_pass++;
      show_pix(11'd309, 11'd29, 1'b0);
      n_total++; if (rgb !== 12'hABC) $display("FAIL rise_px_br got=%h exp=ABC", rgb); else n_pass++;
      show_pix(11'd310, 11'd29, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL rise_px_out got=%h exp=888", rgb); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic cp1, rdy1, pend1, cp2, pend2;
      set_cfg(3'd2, 11'd400, 11'd409, 11'd400, 11'd409, 12'h00F, 1'b1);
      cfg_valid = 1'b1;
      @(posedge pclk); #1;
      cfg_color = 12'h0FF;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", cfg_ready); else n_pass++;
      @(posedge pclk); #1;
      cfg_valid = 1'b0;
      do_vblank(cp1, rdy1, pend1, cp2, pend2);
      n_total++; if (cp1 !== 1'b1) $display("FAIL b2b_commit got=%b exp=1", cp1); else n_pass++;
      show_pix(11'd405, 11'd405, 1'b0);
      n_total++; if (rgb !== 12'h0FF) $display("FAIL b2b_px got=%h exp=0FF", rgb); else n_pass++;
      show_pix(11'd400, 11'd400, 1'b0);
      n_total++; if (rgb !== 12'h0FF) $display("FAIL b2b_px_edge got=%h exp=0FF", rgb); else n_pass++;
      // Out-of-range index: accepted but ignored.
      write(3'd5, 11'd0, 11'd1000, 11'd0, 11'd1000, 12'h123, 1'b1);
      n_total++; if (pending !== 1'b0) $display("FAIL badidx_pending got=%b exp=0", pending); else n_pass++;
      do_vblank(cp1, rdy1, pend1, cp2, pend2);
      n_total++; if (cp1 !== 1'b0) $display("FAIL badidx_commit got=%b exp=0", cp1); else n_pass++;
      n_total++; if (pend1 !== 1'b0) $display("FAIL badidx_pend2 got=%b exp=0", pend1); else n_pass++;
      show_pix(11'd5, 11'd5, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL badidx_px got=%h exp=888", rgb); else n_pass++;
      // Inverted x range never hits.
      write(3'd4, 11'd50, 11'd10, 11'd0, 11'd1000, 12'h321, 1'b1);
      do_vblank(cp1, rdy1, pend1, cp2, pend2);
      n_total++; if (cp1 !== 1'b1) $display("FAIL inv_commit got=%b exp=1", cp1); else n_pass++;
      show_pix(11'd30, 11'd5, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL inv_px_mid got=%h exp=888", rgb); else n_pass++;
      show_pix(11'd50, 11'd5, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL inv_px_edge got=%h exp=888", rgb); else n_pass++;
   endtask

   task automatic test_reset_pending();
      logic cp1, rdy1, pend1, cp2, pend2;
      write(3'd0, 11'd0, 11'd1000, 11'd0, 11'd1000, 12'h555, 1'b1);
      n_total++; if (pending !== 1'b1) $display("FAIL rp_pending got=%b exp=1", pending); else n_pass++;
      hsync = 1'b1; vsync = 1'b1;
      show_pix(11'd150, 11'd100, 1'b0);
      n_total++; if (rgb !== 12'hF00) $display("FAIL rp_prepix got=%h exp=F00", rgb); else n_pass++;
      n_total++; if ({hs, vs} !== 2'b11) $display("FAIL rp_prehsvs got=%b exp=11", {hs, vs}); else n_pass++;
      rst = 1'b1;
      #2;
      n_total++; if (rgb !== 12'h000) $display("FAIL rp_rgb got=%h exp=000", rgb); else n_pass++;
      n_total++; if ({hs, vs} !== 2'b00) $display("FAIL rp_hsvs got=%b exp=00", {hs, vs}); else n_pass++;
      n_total++; if (pending !== 1'b0) $display("FAIL rp_pend got=%b exp=0", pending); else n_pass++;
      n_total++; if (cfg_ready !== 1'b1) $display("FAIL rp_ready got=%b exp=1", cfg_ready); else n_pass++;
      hsync = 1'b0; vsync = 1'b0;
      repeat (2) @(posedge pclk);
      #1 rst = 1'b0;
      @(posedge pclk); #1;
      do_vblank(cp1, rdy1, pend1, cp2, pend2);
      n_total++; if (cp1 !== 1'b0) $display("FAIL rp_nocommit got=%b exp=0", cp1); else n_pass++;
      show_pix(11'd150, 11'd100, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL rp_px_old got=%h exp=888", rgb); else n_pass++;
      show_pix(11'd10, 11'd10, 1'b0);
      n_total++; if (rgb !== 12'h888) $display("FAIL rp_px_new got=%h exp=888", rgb); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_overlap();
      test_vblnk_write();
      test_back_to_back();
      test_reset_pending();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/rect_overlay_ctrl.md
Name: rect_overlay_ctrl

Overview:
- Frame-synchronous controller for the pixel colour datapath. It holds NUM_RECT rectangle descriptors (bounds, colour, enable) that up to one requester writes via a valid/ready port.
- Writes go into shadow registers. The shadow set is committed to the active set atomically at the start of vertical blanking, so a frame never shows a half-updated overlay.
- A 2-stage pipeline computes per-pixel rectangle hits and a fixed-priority colour, and delays hs/vs to match.
- Sits between vga_timing and the r/g/b/hs/vs output registers.

Parameters:
- NUM_RECT, 4, number of rectangle descriptors (2..8); index 0 has the highest priority.
- BG_COLOR, 12'h888, {r,g,b} for an active pixel that hits no enabled rectangle.
- IDX_W, $clog2(NUM_RECT), width of cfg_idx.

Ports:
- pclk  in  1  pixel clock (40 MHz)
- rst  in  1  asynchronous, active-high reset
- hcount  in  11  horizontal pixel count from vga_timing
- vcount  in  11  vertical line count from vga_timing
- hsync  in  1  from vga_timing
- vsync  in  1  from vga_timing
- hblnk  in  1  from vga_timing
- vblnk  in  1  from vga_timing
- cfg_valid  in  1  descriptor write request
- cfg_ready  out  1  write accepted when cfg_valid && cfg_ready
- cfg_idx  in  IDX_W  descriptor index
- cfg_xmin  in  11  inclusive left bound
- cfg_xmax  in  11  inclusive right bound
- cfg_ymin  in  11  inclusive top bound
- cfg_ymax  in  11  inclusive bottom bound
- cfg_color  in  12  {r,g,b}
- cfg_en  in  1  rectangle enable
- pending  out  1  shadow set differs from active set (a commit is outstanding)
- commit_pulse  out  1  one-cycle pulse in the cycle the active set is loaded
- hs  out  1  hsync delayed by 2 cycles
- vs  out  1  vsync delayed by 2 cycles
- r  out  4  pixel red
- g  out  4  pixel green
- b  out  4  pixel blue

Behaviour:
- Interface: one clock (pclk); rst is asynchronous, active-high.
- Reset values:
  - All shadow and active descriptors: en=0, bounds 0, colour 0.
  - State IDLE; cfg_ready=1; pending=0; commit_pulse=0.
  - hs=vs=0; r=g=b=0; internal pipeline and vblnk_q registers cleared.
  - Reset mid-operation discards any pending write set.
- Write port:
  - Handshake occurs when cfg_valid && cfg_ready on a pclk edge. The descriptor cfg_idx in the shadow set is overwritten in full.
  - cfg_ready is registered: it is 0 only in state COMMIT, else 1.
  - cfg_idx >= NUM_RECT is accepted and ignored (no shadow change, no state change).
  - Inputs are don't-care while cfg_valid=0.
- FSM: IDLE, PENDING, COMMIT.
  - vblnk_rise = vblnk && !vblnk_q, where vblnk_q is vblnk registered.
  - IDLE: an accepted write -> PENDING.
  - PENDING: vblnk_rise -> COMMIT; otherwise stay. Further writes stay in PENDING.
  - COMMIT (exactly 1 cycle): active <= shadow (all descriptors); commit_pulse=1; cfg_ready=0; next state IDLE.
  - A write accepted in the same cycle as vblnk_rise is included in the commit: the shadow updates at that edge and COMMIT copies it on the next edge.
  - A write accepted in IDLE in the vblnk_rise cycle also goes to COMMIT next cycle.
  - pending = (state==PENDING) || (state==COMMIT).
- Pixel pipeline (uses the active set only; latency 2 cycles):
  - Stage 1 registers: hit[i] = en[i] && xmin<=hcount<=xmax && ymin<=vcount<=ymax (unsigned, inclusive), plus blank = hblnk||vblnk, hsync, vsync.
  - Stage 2 registers:
    - {r,g,b} = 0 if blank.
    - Otherwise colour of the lowest-index set hit.
    - Otherwise BG_COLOR.
    - hs and vs are also registered here.
  - A rectangle with xmin>xmax or ymin>ymax never hits; this is legal and not an error.
  - The active set changes only during vblank, so no visible pixel is affected by a commit.

Test Plan:
- Reset release, no writes, one frame -> every active pixel = 12'h888; blanking pixels = 0; hs/vs equal hsync/vsync delayed by exactly 2 pclk.
- Write idx0 = {x 100..199, y 50..149, 12'hF00, en=1} mid-frame at vcount=300 -> rest of the current frame is still 12'h888. pending=1 until commit_pulse, one cycle after vblnk rises. Next frame: pixel (100,50) and (199,149) = F00; (200,50) and (99,149) = 888.
- Overlap: idx1 = {x 150..249, y 100..199, 12'h0F0}, idx0 as above -> (150,100) = F00 (idx0 wins); (220,180) = 0F0.
- Write asserted in the exact vblnk_rise cycle -> accepted (cfg_ready=1). cfg_ready=0 in the following COMMIT cycle. The written descriptor is visible in the next frame.
- Back-to-back writes to idx2 (colour 00F, then 0FF) in one frame -> only 0FF is displayed next frame. A write with cfg_idx=NUM_RECT causes no change and pending stays 0.
- Assert rst while PENDING -> outputs 0, pending=0, cfg_ready=1. After release, no commit occurs and the frame shows 12'h888 only.
